// File: rtl/de_multiplexer.sv
// Registered address decoder: one-cycle enable strobes for two write targets.
// Optional sticky unmapped-address flag built only when DEMUX_ADDR_ERR_EN is defined.
module de_multiplexer #(
  parameter int unsigned                ADDR_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0]      EN0_ADDR   = 3'b001,
  parameter logic [ADDR_WIDTH-1:0]      EN1_ADDR   = 3'b010
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  output logic                  enable0,
  output logic                  enable1,
  output logic                  addr_err
);

  // Two targets sharing one address would break mutual exclusion of the strobes.
  if (EN0_ADDR == EN1_ADDR) begin : g_addr_clash
    $error("de_multiplexer: EN0_ADDR and EN1_ADDR must differ");
  end

  // Case equality keeps X/Z addresses from matching either target.
  logic w_hit0;
  logic w_hit1;
  assign w_hit0 = (ADDR === EN0_ADDR);
  assign w_hit1 = (ADDR === EN1_ADDR);

  logic r_en0;
  logic r_en1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_en0 <= 1'b0;
      r_en1 <= 1'b0;
    end else begin
      r_en0 <= w_hit0;
      r_en1 <= w_hit1;
    end
  end

  assign enable0 = r_en0;
  assign enable1 = r_en1;

`ifdef DEMUX_ADDR_ERR_EN
  logic w_unmapped;
  logic r_err;
  assign w_unmapped = ~w_hit0 & ~w_hit1;

  // Sticky until RESET so software can poll it after a burst.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_err <= 1'b0;
    end else if (w_unmapped) begin
      r_err <= 1'b1;
    end
  end

  assign addr_err = r_err;
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_de_multiplexer.sv
// Bench for de_multiplexer: directed scenarios then random addresses/resets,
// scored against a target-lookup model through an expected-value queue.
module tb_de_multiplexer;

  localparam logic [2:0] EN0 = 3'b001;
  localparam logic [2:0] EN1 = 3'b010;

  logic       CLK;
  logic       RESET;
  logic [2:0] ADDR;
  logic       enable0;
  logic       enable1;
  logic       addr_err;

  int checks;
  int failures;

  logic [2:0] exp_q[$];
  logic       model_err;

  de_multiplexer #(
    .ADDR_WIDTH(3),
    .EN0_ADDR  (EN0),
    .EN1_ADDR  (EN1)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ADDR    (ADDR),
    .enable0 (enable0),
    .enable1 (enable1),
    .addr_err(addr_err)
  );

  // Clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%b expected=%b at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: which target (if any) an address selects; 0 none, 1 target0, 2 target1.
  function automatic int target_of(input logic [2:0] a);
    if (a === EN0) return 1;
    if (a === EN1) return 2;
    return 0;
  endfunction

  function automatic logic [2:0] model_next(input logic rst, input logic [2:0] a);
    int t;
    logic [2:0] r;
    if (rst) begin
      model_err = 1'b0;
      return 3'b000;
    end
    t = target_of(a);
`ifdef DEMUX_ADDR_ERR_EN
    if (t == 0) model_err = 1'b1;
`endif
    r = 3'b000;
    r[0] = (t == 1);
    r[1] = (t == 2);
    r[2] = model_err;
    return r;
  endfunction

  task automatic score();
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 3'b001, 3'b000);
    end else begin
      e = exp_q.pop_front();
      check("outs{err,en1,en0}", {addr_err, enable1, enable0}, e);
      check("mutex", {2'b00, enable0 & enable1}, 3'b000);
      check("no_x", {2'b00, $isunknown({addr_err, enable1, enable0})}, 3'b000);
    end
  endtask

  // Driver: apply inputs away from the edge, predict, then sample 1 unit after the edge.
  task automatic drive(input logic rst, input logic [2:0] a);
    RESET = rst;
    ADDR  = a;
    exp_q.push_back(model_next(rst, a));
    @(posedge CLK);
    #1;
    score();
  endtask

  initial begin
    logic [2:0] xv;
    checks    = 0;
    failures  = 0;
    model_err = 1'b0;
    RESET     = 1'b1;
    ADDR      = EN0;
    #2;

    // Reset held two cycles with a mapped address present
    drive(1'b1, 3'b001);
    drive(1'b1, 3'b001);

    // Basic decode
    drive(1'b0, 3'b001);
    drive(1'b0, 3'b010);

    // Alternation
    for (int i = 0; i < 4; i++) drive(1'b0, (i % 2 == 0) ? 3'b001 : 3'b010);

    // Level behaviour on repeated address
    for (int i = 0; i < 3; i++) drive(1'b0, 3'b001);

    // Unmapped addresses; error flag must persist after returning to a mapped address
    drive(1'b0, 3'b000);
    drive(1'b0, 3'b111);
    drive(1'b0, 3'b001);
    drive(1'b0, 3'b001);

    // Mid-stream reset pulse with target1 held
    drive(1'b0, 3'b010);
    drive(1'b1, 3'b010);
    drive(1'b0, 3'b010);
    drive(1'b0, 3'b010);

    // Address with an unknown bit
    xv = 3'bx01;
    drive(1'b0, xv);
    drive(1'b0, 3'b010);
    drive(1'b1, 3'b000);

    // Random addresses with occasional resets
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)));
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
